// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipelined_addsub_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES equal chunks with one
// register stage per chunk; a single global advance enable freezes the whole pipe on stall.
module pipelined_addsub #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned W = N / STAGES;

    logic         out_valid;
    logic         adv;
    logic         accept;
    logic [N-1:0] b_eff;
    logic         c0;

    assign adv    = !out_valid || bus.out_ready;
    assign accept = bus.in_valid && adv;
    assign b_eff  = bus.op[0] ? ~bus.b : bus.b;

    always_comb begin
        case (bus.op)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = 1'b1;
            default: c0 = bus.cin;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operands shrink and the result grows by one chunk per stage, which is the input skew
        // and output deskew folded into the stage registers themselves.
        localparam int unsigned RI = N - k * W;
        localparam int unsigned SW = (k + 1) * W;

        logic          v_in;
        logic          c_in;
        logic [RI-1:0] a_in;
        logic [RI-1:0] b_in;
        logic [W:0]    chunk;
        logic [SW-1:0] s_nxt;

        logic          valid_q;
        logic          carry_q;
        logic [SW-1:0] sum_q;

        if (k == 0) begin : g_head
            assign v_in  = accept;
            assign c_in  = c0;
            assign a_in  = bus.a;
            assign b_in  = b_eff;
            assign s_nxt = chunk[W-1:0];
        end else begin : g_body
            assign v_in  = g_stage[k-1].valid_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign a_in  = g_stage[k-1].g_ops.a_q;
            assign b_in  = g_stage[k-1].g_ops.b_q;
            assign s_nxt = {chunk[W-1:0], g_stage[k-1].sum_q};
        end

        assign chunk = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        // Data only moves with a valid beat, so the last stage keeps its last valid result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                if (v_in) begin
                    carry_q <= chunk[W];
                    sum_q   <= s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [RI-W-1:0] a_q;
            logic [RI-W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_in[RI-1:W];
                    b_q <= b_in[RI-1:W];
                end
            end
        end

        if (k == STAGES - 1) begin : g_flags
            logic ovf_q;

            // The top chunk still carries the operand sign bits in its MSB position.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= (a_in[W-1] == b_in[W-1]) && (chunk[W-1] != a_in[W-1]);
                end
            end
        end
    end

    assign out_valid     = g_stage[STAGES-1].valid_q;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = adv;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = g_stage[STAGES-1].g_flags.ovf_q;
    assign bus.zero      = (g_stage[STAGES-1].sum_q == '0);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (STAGES = 1, 4, 8) share one stimulus stream,
// each with its own in-order scoreboard fed by an arithmetic reference model.
module tb_pipelined_addsub;
    localparam int unsigned N = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;

    logic [2:0]   rdy;
    logic [2:0]   ov;
    logic [2:0]   co;
    logic [2:0]   vf;
    logic [2:0]   zr;
    logic [N-1:0] sm [3];

    res_t cur_exp = '0;
    res_t q0[$];
    res_t q1[$];
    res_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 4 : 8);

        pipelined_addsub_if #(.N(N)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.op        = op;
        assign bus.cin       = cin;
        assign bus.out_ready = out_ready;
        assign rdy[g]        = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign co[g]         = bus.cout;
        assign vf[g]         = bus.ovf;
        assign zr[g]         = bus.zero;
        assign sm[g]         = bus.sum;

        pipelined_addsub #(.N(N), .STAGES(S)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    function automatic int stg(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    endfunction

    // Reference: plain wide integer arithmetic on the operation's meaning.
    function automatic res_t model(input logic [1:0] o, input logic [N-1:0] x,
                                   input logic [N-1:0] y, input logic c);
        longint ux, uy, sx, sy, u, s, ci;
        res_t   r;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ci = longint'(c);
        case (o)
            2'b00:   begin u = ux + uy;           s = sx + sy;           end
            2'b01:   begin u = ux - uy;           s = sx - sy;           end
            2'b10:   begin u = ux + uy + ci;      s = sx + sy + ci;      end
            default: begin u = ux - uy - 1 + ci;  s = sx - sy - 1 + ci;  end
        endcase
        r.sum  = u[N-1:0];
        r.cout = o[0] ? (u >= 0) : (u >= 64'sh1_0000_0000);
        r.ovf  = (s > SMAX) || (s < SMIN);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int g, input res_t r);
        case (g)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic pop(input int g, output res_t r, output bit ok);
        r  = '0;
        ok = 1'b1;
        case (g)
            0:       if (q0.size() == 0) ok = 1'b0; else r = q0.pop_front();
            1:       if (q1.size() == 0) ok = 1'b0; else r = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else r = q2.pop_front();
        endcase
    endtask

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : ((g == 1) ? q1.size() : q2.size());
    endfunction

    // One clock: sample handshakes on the falling edge, then return 1 time unit after rising.
    task automatic step();
        res_t r;
        bit   ok;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            if (ov[g] && out_ready) begin
                pop(g, r, ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_s%0d: got out_valid=1 sum=%0h, expected none",
                             stg(g), sm[g]);
                end else begin
                    chk($sformatf("sum_s%0d", stg(g)), 64'(sm[g]), 64'(r.sum));
                    chk($sformatf("cout_s%0d", stg(g)), 64'(co[g]), 64'(r.cout));
                    chk($sformatf("ovf_s%0d", stg(g)), 64'(vf[g]), 64'(r.ovf));
                    chk($sformatf("zero_s%0d", stg(g)), 64'(zr[g]), 64'(r.zero));
                end
            end
            if (rst_n && in_valid && rdy[g]) push(g, cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic c, input res_t e);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cin      = c;
        cur_exp  = e;
    endtask

    task automatic drive_rand();
        logic [1:0]   o;
        logic [N-1:0] x, y;
        logic         c;
        o = 2'($urandom_range(0, 3));
        x = $urandom;
        y = $urandom;
        c = 1'($urandom_range(0, 1));
        drive(o, x, y, c, model(o, x, y, c));
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_out_valid_s%0d", tag, stg(g)), 64'(ov[g]), 64'(0));
            chk($sformatf("%s_sum_s%0d", tag, stg(g)), 64'(sm[g]), 64'(0));
            chk($sformatf("%s_cout_s%0d", tag, stg(g)), 64'(co[g]), 64'(0));
            chk($sformatf("%s_ovf_s%0d", tag, stg(g)), 64'(vf[g]), 64'(0));
            chk($sformatf("%s_zero_s%0d", tag, stg(g)), 64'(zr[g]), 64'(1));
            chk($sformatf("%s_in_ready_s%0d", tag, stg(g)), 64'(rdy[g]), 64'(1));
        end
    endtask

    task automatic chk_drained(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_pending_s%0d", tag, stg(g)), 64'(qsize(g)), 64'(0));
        end
    endtask

    initial begin
        vec_t         vt [14];
        logic [N-1:0] snap [3];

        vt[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vt[1]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vt[2]  = '{2'b11, 32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vt[3]  = '{2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vt[4]  = '{2'b00, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, '{32'h0100_0000, 1'b0, 1'b0, 1'b0}};
        vt[5]  = '{2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vt[6]  = '{2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vt[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        vt[8]  = '{2'b11, 32'h0000_000A, 32'h0000_0003, 1'b0, '{32'h0000_0006, 1'b1, 1'b0, 1'b0}};
        vt[9]  = '{2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
        vt[10] = '{2'b01, 32'h0000_0003, 32'h0000_0001, 1'b0, '{32'h0000_0002, 1'b1, 1'b0, 1'b0}};
        vt[11] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
        vt[12] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vt[13] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, '{32'h0001_FFFE, 1'b0, 1'b0, 1'b0}};

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: single op into empty pipes, out_valid exactly after edge STAGES-1
        drive(vt[0].op, vt[0].a, vt[0].b, vt[0].cin, vt[0].exp);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("latency_c%0d_s%0d", c, stg(g)), 64'(ov[g]),
                    64'(c == stg(g) - 1));
            end
            step();
        end
        chk_drained("latency");

        // Directed vectors, back to back
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk_drained("table");

        // 16 back-to-back random ops at full throughput
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            step();
            for (int g = 0; g < 3; g++) begin
                if (i >= stg(g) - 1) chk($sformatf("stream_valid_s%0d", stg(g)), 64'(ov[g]), 64'(1));
            end
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk_drained("stream");

        // Random valid/ready handshake
        for (int i = 0; i < 60; i++) begin
            drive_rand();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        chk_drained("random");

        // Backpressure: fill every pipe, then hold out_ready low for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            step();
        end
        for (int g = 0; g < 3; g++) snap[g] = sm[g];
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("stall%0d_in_ready_s%0d", i, stg(g)), 64'(rdy[g]), 64'(0));
                chk($sformatf("stall%0d_out_valid_s%0d", i, stg(g)), 64'(ov[g]), 64'(1));
                chk($sformatf("stall%0d_sum_s%0d", i, stg(g)), 64'(sm[g]), 64'(snap[g]));
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();
        chk_drained("stall");

        // Asynchronous reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (12) step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("post_reset_idle_s%0d", stg(g)), 64'(ov[g]), 64'(0));
        end

        // Pipe still works after the reset
        for (int i = 0; i < 4; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk_drained("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake and status flags. It is the successor to the single-cycle ripple adder used by the RISC datapath. The carry chain is split into STAGES equal chunks, one register stage per chunk, so wide operands close timing at full clock rate. Throughput is one operation per cycle. The block feeds the ALU result path and the address-generation unit.

## Interface
- N, default 32: operand/result width; N % STAGES must equal 0.
- STAGES, default 4: pipeline depth and chunk count; 1 ≤ STAGES ≤ N; chunk width W = N/STAGES.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low, synchronous deassert handled upstream.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- op  input  2  operation: 00 ADD a+b, 01 SUB a−b, 10 ADC a+b+cin, 11 SBC a+~b+cin.
- cin  input  1  carry-in; used only for ADC/SBC.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result.
- cout  output  1  carry out of bit N−1; for SUB/SBC, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- Operand prep at accept: b_eff = b for ADD/ADC and ~b for SUB/SBC. c0 = 0 for ADD, 1 for SUB, and cin for ADC/SBC.
- Stage k (0..STAGES−1) adds chunk k of a and b_eff, bits [kW+W−1:kW], with the carry registered from stage k−1. Stage 0 uses c0.
- Input skew: chunk k operands are delayed k cycles before entering stage k.
- Output deskew: the chunk k result is delayed STAGES−1−k cycles so all chunks emerge aligned.
- The signs a[N−1] and b_eff[N−1] travel with the top chunk. ovf = (a_msb == b_eff_msb) && (sum[N−1] != a_msb).
- cout is the carry out of the final stage. zero is computed combinationally from the registered sum.
- Each stage holds a valid bit. A single global advance enable is used: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 1, all stages shift one position, and in_valid && in_ready loads stage 0.
  - When adv = 0, every register holds.
- Bubbles propagate as valid = 0. Data registers in bubble slots are don't-care internally, but sum/cout/ovf must hold their last valid values while out_valid = 0.
- No state machine beyond the valid shift register. A cin or op change while not accepted has no effect.

## Timing
- Reset (rst_n low, any time, including mid-operation): all valid bits = 0, all data registers = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 1. In-flight operations are discarded.
- While rst_n is low, in_ready = 1 (adv is true because out_valid = 0), but nothing is captured until rst_n returns high.
- Latency: an operation accepted on edge t appears with out_valid = 1 after edge t+STAGES−1. For STAGES = 1 it appears after edge t, i.e. the result is registered once.
- Throughput: one result per cycle while out_ready stays high.
- Stall: when out_valid && !out_ready, the whole pipe freezes, in_ready = 0, and outputs stay stable until the cycle out_ready is seen high.
- Simultaneous in_valid and output drain in the same cycle is allowed, with no bubble inserted.
- in_ready depends combinationally on out_ready. This is the only combinational input-to-output path.
- Wrap-around: the result is modulo 2^N, and the carry is reported only via cout.

## Test plan
- N=32, STAGES=4, ADD 0xFFFFFFFF + 0x00000001 → sum 0x00000000, cout 1, ovf 0, zero 1. out_valid rises exactly 3 edges after the accept edge, so accept is edge 0 and out_valid is high after edge 3.
- SUB 0x80000000 − 0x00000001 → sum 0x7FFFFFFF, cout 1, ovf 1, zero 0.
- SBC with a=5, b=7, cin=1 → 0xFFFFFFFE, cout 0, ovf 0. ADC with 0x7FFFFFFF + 0 + cin=1 → 0x80000000, ovf 1.
- Cross-chunk carry ripple: ADD 0x00FFFFFF + 0x00000001 → 0x01000000. Issue 16 back-to-back random ops with out_ready = 1 and compare each against a reference model in order, 1 result per cycle.
- Backpressure: hold out_ready = 0 for 5 cycles with a full pipe. Required: in_ready = 0, sum/out_valid stable, and no loss or duplication after release.
- Reset mid-flight: pulse rst_n low asynchronously with 3 ops in flight. Required: outputs go to reset values immediately, and none of the 3 results ever appears. Repeat the add/sub checks with STAGES=1 and STAGES=8.
